// File: rtl/gate_exerciser_pkg.sv
// Shared types and constants for the 2-input gate exerciser: FSM encoding,
// vector count and the common gate truth tables.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;

  // Bit i is the expected gate output for input {a,b} = i.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_exerciser_if.sv
// Control/status and gate-under-test signals of the gate exerciser.
interface gate_exerciser_if;
  // start is a request sampled only while idle; busy covers the run, done
  // pulses once when results are final; pass/err/first_fail hold until the
  // next accepted start.
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;
  logic       dut_a;
  logic       dut_b;
  logic       dut_y;

  modport master (
    input  start, dut_y,
    output busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dut_a, dut_b
  );

  modport slave (
    output start, dut_y,
    input  busy, done, pass, err_count, first_fail_vec, first_fail_valid,
           dut_a, dut_b
  );
endinterface

// File: rtl/gate_exerciser.sv
// Drives the four {a,b} vectors into a gate, samples its output after a settle
// interval and reports pass/fail, mismatch count and the first failing vector.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_NAND,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  gate_exerciser_if.master   bus,
  output state_e             dbg_state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_count_q, err_count_d;
  logic [1:0] first_fail_vec_q, first_fail_vec_d;
  logic       first_fail_valid_q, first_fail_valid_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      vec_q              <= '0;
      cnt_q              <= '0;
      err_count_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
      pass_q             <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      vec_q              <= vec_d;
      cnt_q              <= cnt_d;
      err_count_q        <= err_count_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
      pass_q             <= pass_d;
      busy_q             <= busy_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    vec_d              = vec_q;
    cnt_d              = cnt_q;
    err_count_d        = err_count_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;
    pass_d             = pass_q;
    busy_d             = busy_q;
    mismatch           = (bus.dut_y != TRUTH_TABLE[vec_q]);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          vec_d              = '0;
          cnt_d              = '0;
          err_count_d        = '0;
          first_fail_valid_d = 1'b0;
          first_fail_vec_d   = '0;
          pass_d             = 1'b0;
          busy_d             = 1'b1;
          state_d            = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count_q + 3'd1;
          if (!first_fail_valid_q) begin
            first_fail_vec_d   = vec_q;
            first_fail_valid_d = 1'b1;
          end
        end
        // Pass is judged on the count including this last sample.
        if (vec_q == LAST_VEC) begin
          pass_d  = (err_count_d == 3'd0);
          busy_d  = 1'b0;
          state_d = ST_REPORT;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.busy             = busy_q;
  assign bus.done             = (state_q == ST_REPORT);
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.first_fail_vec   = first_fail_vec_q;
  assign bus.first_fail_valid = first_fail_valid_q;
  assign bus.dut_a            = busy_q & vec_q[1];
  assign bus.dut_b            = busy_q & vec_q[0];
  assign dbg_state            = state_q;

endmodule
